tc0480scp_gfx_arbiter: RTL and testbench

//  Shares the single TC0480SCP tile-graphics ROM port (toggle req/ack) between NUM_REQ layer fetchers.

---
 rtl/tc0480scp_pkg.sv | 13 +
 rtl/tc0480scp_rr_pick.sv | 28 ++
 rtl/tc0480scp_gfx_arbiter.sv | 148 ++++++++++++++
 tb/tb_tc0480scp_gfx_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tc0480scp_pkg.sv
// Shared types and ROM geometry for the TC0480SCP graphics datapath.
package tc0480scp_pkg;

    localparam int unsigned ROM_ADDR_W = 23;
    localparam int unsigned ROM_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        DELIVER
    } gfx_arb_state_t;

endpackage

// File: rtl/tc0480scp_rr_pick.sv
// Round-robin picker: first set bit of pending, scanning upward from ptr with wrap.
module tc0480scp_rr_pick #(
    parameter int unsigned N = 4,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  pending,
    input  logic [IW-1:0] ptr,
    output logic          valid_c,
    output logic [IW-1:0] index_c
);

    logic [IW-1:0] cand;

    // Scan ptr, ptr+1, ... ; N is a power of two so the IW-bit add wraps for free.
    always_comb begin
        valid_c = 1'b0;
        index_c = ptr;
        cand    = ptr;
        for (int unsigned k = 0; k < N; k++) begin
            cand = ptr + IW'(k);
            if (!valid_c && pending[cand]) begin
                valid_c = 1'b1;
                index_c = cand;
            end
        end
    end

endmodule

// File: rtl/tc0480scp_gfx_arbiter.sv
// Round-robin share of the tile ROM port between layer fetchers, toggle handshakes on both sides.
module tc0480scp_gfx_arbiter
    import tc0480scp_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = ROM_ADDR_W,
    parameter int unsigned DATA_W  = ROM_DATA_W,
    localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_toggle,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0]        req_blank,
    output logic [NUM_REQ-1:0]        ack_toggle,
    output logic                      load,
    output logic [IDX_W-1:0]          load_index,
    output logic [DATA_W-1:0]         load_data,
    output logic [NUM_REQ-1:0]        overrun,
    output logic [ADDR_W-1:0]         rom_address,
    output logic                      rom_req,
    input  logic                      rom_ack,
    input  logic [DATA_W-1:0]         rom_data
);

    gfx_arb_state_t      state_q, state_d;
    logic [IDX_W-1:0]    sel_q, sel_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [NUM_REQ-1:0]  prev_req_q, prev_req_d;
    logic [NUM_REQ-1:0]  overrun_q, overrun_d;
    logic                load_q, load_d;
    logic [IDX_W-1:0]    load_index_q, load_index_d;
    logic [DATA_W-1:0]   load_data_q, load_data_d;
    logic [ADDR_W-1:0]   rom_address_q, rom_address_d;
    logic                rom_req_q, rom_req_d;

    logic [NUM_REQ-1:0]  pending;
    logic [NUM_REQ-1:0]  was_pending;
    logic [NUM_REQ-1:0]  deliver_mask;
    logic                pick_valid;
    logic [IDX_W-1:0]    pick_index;
    logic [ADDR_W-1:0]   addr_arr [NUM_REQ];

    // Split the flat address bus per requester.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
        end
    end

    assign pending     = req_toggle ^ ack_q;
    assign was_pending = prev_req_q ^ ack_q;

    tc0480scp_rr_pick #(.N(NUM_REQ)) u_pick (
        .pending (pending),
        .ptr     (rr_ptr_q),
        .valid_c (pick_valid),
        .index_c (pick_index)
    );

    // Grant / ROM wait / deliver sequencing plus sticky overrun tracking.
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        rr_ptr_d      = rr_ptr_q;
        ack_d         = ack_q;
        prev_req_d    = req_toggle;
        load_d        = 1'b0;
        load_index_d  = load_index_q;
        load_data_d   = load_data_q;
        rom_address_d = rom_address_q;
        rom_req_d     = rom_req_q;
        deliver_mask  = '0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    sel_d = pick_index;
                    if (req_blank[pick_index]) begin
                        load_data_d = '0;
                        state_d     = DELIVER;
                    end else begin
                        rom_address_d = addr_arr[pick_index];
                        rom_req_d     = ~rom_req_q;
                        state_d       = WAIT_ACK;
                    end
                end
            end
            WAIT_ACK: begin
                if (rom_ack == rom_req_q) begin
                    load_data_d = rom_data;
                    state_d     = DELIVER;
                end
            end
            DELIVER: begin
                load_d              = 1'b1;
                load_index_d        = sel_q;
                ack_d[sel_q]        = ~ack_q[sel_q];
                deliver_mask[sel_q] = 1'b1;
                rr_ptr_d            = sel_q + IDX_W'(1);
                state_d             = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A toggle coinciding with its own delivery is a fresh request, not an overrun.
        overrun_d = overrun_q | ((req_toggle ^ prev_req_q) & was_pending & ~deliver_mask);
    end

    // State register; reset aligns rom_req to rom_ack so no phantom transfer exists.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            sel_q         <= '0;
            rr_ptr_q      <= '0;
            ack_q         <= '0;
            prev_req_q    <= req_toggle;
            overrun_q     <= '0;
            load_q        <= 1'b0;
            load_index_q  <= '0;
            load_data_q   <= '0;
            rom_address_q <= '0;
            rom_req_q     <= rom_ack;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            rr_ptr_q      <= rr_ptr_d;
            ack_q         <= ack_d;
            prev_req_q    <= prev_req_d;
            overrun_q     <= overrun_d;
            load_q        <= load_d;
            load_index_q  <= load_index_d;
            load_data_q   <= load_data_d;
            rom_address_q <= rom_address_d;
            rom_req_q     <= rom_req_d;
        end
    end

    assign ack_toggle  = ack_q;
    assign load        = load_q;
    assign load_index  = load_index_q;
    assign load_data   = load_data_q;
    assign overrun     = overrun_q;
    assign rom_address = rom_address_q;
    assign rom_req     = rom_req_q;

endmodule

// File: tb/tb_tc0480scp_gfx_arbiter.sv
// Bench for the tile ROM arbiter: directed scenarios plus randomized traffic against a job-level model.
module tb_tc0480scp_gfx_arbiter;

    localparam int N  = 4;
    localparam int AW = 23;
    localparam int DW = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_toggle;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_blank;
    logic [N-1:0]    ack_toggle;
    logic            load;
    logic [1:0]      load_index;
    logic [DW-1:0]   load_data;
    logic [N-1:0]    overrun;
    logic [AW-1:0]   rom_address;
    logic            rom_req;
    logic            rom_ack = 1'b0;
    logic [DW-1:0]   rom_data = '0;

    tc0480scp_gfx_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req_toggle  (req_toggle),
        .req_addr    (req_addr),
        .req_blank   (req_blank),
        .ack_toggle  (ack_toggle),
        .load        (load),
        .load_index  (load_index),
        .load_data   (load_data),
        .overrun     (overrun),
        .rom_address (rom_address),
        .rom_req     (rom_req),
        .rom_ack     (rom_ack),
        .rom_data    (rom_data)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ROM responder: acks a mismatched request after rom_delay cycles unless stalled.
    int rom_delay = 3;
    bit rom_stall = 1'b0;
    int rom_cnt   = 0;

    function automatic logic [63:0] rom_word(logic [22:0] a);
        if (a == 23'h001230) return 64'hFEDC_BA98_7654_3210;
        return {9'h0, a, 32'h0} ^ {32'hA5A5_0000, 9'h0, a};
    endfunction

    always @(negedge clk) begin
        if (rom_req === rom_ack) begin
            rom_cnt = 0;
        end else if (!rom_stall) begin
            if (rom_cnt + 1 >= rom_delay) begin
                rom_ack  = ~rom_ack;
                rom_data = rom_word(rom_address);
                rom_cnt  = 0;
            end else begin
                rom_cnt++;
            end
        end
    end

    // Job-level reference: one job at a time; grant -> (ROM wait) -> deliver.
    logic [N-1:0]  m_ack, m_ovr, m_prev;
    logic          m_load;
    logic [1:0]    m_idx;
    logic [DW-1:0] m_data;
    logic [AW-1:0] m_addr;
    logic          m_rom_req;
    int            m_rr;
    bit            job_active, job_rom, delivering;
    int            job_sel;

    always @(posedge clk) begin
        if (reset) begin
            m_ack = '0; m_ovr = '0; m_prev = req_toggle; m_load = 1'b0; m_idx = '0;
            m_data = '0; m_addr = '0; m_rom_req = rom_ack; m_rr = 0;
            job_active = 1'b0; job_rom = 1'b0; job_sel = 0;
        end else begin
            delivering = job_active && !job_rom;
            for (int i = 0; i < N; i++) begin
                if (req_toggle[i] != m_prev[i] && m_prev[i] != m_ack[i] && !(delivering && job_sel == i))
                    m_ovr[i] = 1'b1;
            end
            m_prev = req_toggle;
            m_load = 1'b0;
            if (delivering) begin
                m_load          = 1'b1;
                m_idx           = 2'(job_sel);
                m_ack[job_sel]  = ~m_ack[job_sel];
                m_rr            = (job_sel + 1) % N;
                job_active      = 1'b0;
            end else if (job_active) begin
                if (rom_ack == m_rom_req) begin
                    m_data  = rom_data;
                    job_rom = 1'b0;
                end
            end else begin
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (m_rr + k) % N;
                    if (!job_active && req_toggle[i] != m_ack[i]) begin
                        job_active = 1'b1;
                        job_sel    = i;
                        if (req_blank[i]) begin
                            job_rom = 1'b0;
                            m_data  = '0;
                        end else begin
                            job_rom   = 1'b1;
                            m_addr    = req_addr[i*AW +: AW];
                            m_rom_req = ~m_rom_req;
                        end
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every meaningful output against the model.
    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("ack_toggle", 64'(ack_toggle), 64'(m_ack));
            check("overrun", 64'(overrun), 64'(m_ovr));
            check("load", 64'(load), 64'(m_load));
            check("rom_req", 64'(rom_req), 64'(m_rom_req));
            if (m_load) begin
                check("load_index", 64'(load_index), 64'(m_idx));
                check("load_data", load_data, m_data);
            end
            if (job_active && job_rom) check("rom_address", 64'(rom_address), 64'(m_addr));
        end
    end

    // Observation logs for the directed scenarios.
    int            rom_toggles = 0;
    logic          last_rom_req;
    int            load_log[$];
    logic [DW-1:0] data_log[$];

    always @(negedge clk) begin
        if (!reset && rom_req !== last_rom_req) rom_toggles++;
        last_rom_req = rom_req;
        if (load) begin
            load_log.push_back(int'(load_index));
            data_log.push_back(load_data);
        end
    end

    task automatic step(int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        req_toggle = '0;
        step(2);
        reset = 1'b0;
    endtask

    task automatic post(int i, bit blank, logic [AW-1:0] a);
        req_addr[i*AW +: AW] = a;
        req_blank[i]         = blank;
        req_toggle[i]        = ~req_toggle[i];
    endtask

    task automatic clear_logs();
        load_log.delete();
        data_log.delete();
    endtask

    task automatic wait_loads(int n, int budget, string name);
        int c = 0;
        while (load_log.size() < n && c < budget) begin
            step();
            c++;
        end
        tests++;
        if (load_log.size() < n) begin
            fails++;
            $display("FAIL %s: timeout with %0d loads, needed %0d", name, load_log.size(), n);
        end
    endtask

    int t0;

    initial begin
        reset = 1'b1; req_toggle = '0; req_blank = '0; req_addr = '0;
        step(1);
        chk_en = 1'b1;
        step(1);
        reset = 1'b0;

        // Reset values
        check("rst_ack", 64'(ack_toggle), 64'h0);
        check("rst_load", 64'(load), 64'h0);
        check("rst_overrun", 64'(overrun), 64'h0);
        check("rst_rom_address", 64'(rom_address), 64'h0);
        check("rst_rom_req", 64'(rom_req), 64'h0);

        // Single ROM request from requester 2
        clear_logs(); t0 = rom_toggles; rom_delay = 5;
        post(2, 1'b0, 23'h001230);
        step(2);
        check("t1_rom_address", 64'(rom_address), 64'h001230);
        wait_loads(1, 50, "t1_load");
        if (load_log.size() >= 1) begin
            check("t1_index", 64'(load_log[0]), 64'd2);
            check("t1_data", data_log[0], 64'hFEDC_BA98_7654_3210);
        end
        check("t1_ack", 64'(ack_toggle), 64'b0100);
        check("t1_rom_toggles", 64'(rom_toggles - t0), 64'd1);

        // All four at once from rr_ptr=0
        do_reset();
        clear_logs(); t0 = rom_toggles; rom_delay = 3;
        for (int i = 0; i < N; i++) post(i, 1'b0, 23'(32'h100 * (i + 1)));
        wait_loads(4, 200, "t2_loads");
        for (int k = 0; k < N; k++)
            if (k < load_log.size()) check($sformatf("t2_order%0d", k), 64'(load_log[k]), 64'(k));
        check("t2_rom_toggles", 64'(rom_toggles - t0), 64'd4);
        check("t2_overrun", 64'(overrun), 64'h0);

        // Pointer wrapped to 0: requester 0 ahead of 3
        step(2); clear_logs();
        post(0, 1'b0, 23'h000777);
        post(3, 1'b0, 23'h003333);
        wait_loads(2, 100, "t4_loads");
        if (load_log.size() >= 2) begin
            check("t4_first", 64'(load_log[0]), 64'd0);
            check("t4_second", 64'(load_log[1]), 64'd3);
        end

        // Blank tile: no ROM access, load two cycles after the request
        step(2); clear_logs(); t0 = rom_toggles;
        post(1, 1'b1, 23'h000abc);
        step(1);
        check("t3_early_load", 64'(load), 64'h0);
        step(1);
        check("t3_load", 64'(load), 64'h1);
        check("t3_index", 64'(load_index), 64'd1);
        check("t3_data", load_data, 64'h0);
        check("t3_rom_toggles", 64'(rom_toggles - t0), 64'd0);
        req_blank[1] = 1'b0;

        // Overrun on requester 0 while the ROM stalls on requester 1
        step(2); clear_logs(); rom_stall = 1'b1;
        post(1, 1'b0, 23'h004444);
        step(2);
        post(0, 1'b0, 23'h005555);
        step(1);
        req_toggle[0] = ~req_toggle[0];
        step(2);
        check("t5_overrun_set", 64'(overrun), 64'b0001);
        rom_stall = 1'b0;
        wait_loads(1, 50, "t5_load");
        if (load_log.size() >= 1) check("t5_index", 64'(load_log[0]), 64'd1);
        step(20);
        check("t5_overrun_sticky", 64'(overrun), 64'b0001);
        check("t5_load_count", 64'(load_log.size()), 64'd1);

        // Reset during WAIT_ACK with rom_ack=1
        if (rom_ack == 1'b0) begin
            clear_logs();
            post(2, 1'b0, 23'h006666);
            wait_loads(1, 50, "t6_prep");
            step(2);
        end
        rom_stall = 1'b1;
        post(3, 1'b0, 23'h007777);
        step(3);
        check("t6_in_flight", 64'(rom_req), 64'h0);
        do_reset();
        clear_logs();
        check("t6_rom_req_after_reset", 64'(rom_req), 64'h1);
        check("t6_load_after_reset", 64'(load), 64'h0);
        rom_stall = 1'b0;
        step(5);
        check("t6_no_phantom", 64'(load_log.size()), 64'd0);
        post(1, 1'b0, 23'h001111);
        step(2);
        check("t6_rom_req_new", 64'(rom_req), 64'h0);
        wait_loads(1, 50, "t6_load");
        if (load_log.size() >= 1) check("t6_index", 64'(load_log[0]), 64'd1);

        // Randomized traffic, checked cycle by cycle against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rom_delay = int'($urandom_range(1, 6));
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 99) < 8) post(i, $urandom_range(0, 3) == 0, 23'($urandom));
            step(1);
        end
        step(100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1);
    end

endmodule
